// File: rtl/axi_clock_div_ctrl.sv
// Reload sequencer for the configurable clock divider: owns clockDiv and the
// divider reset, applies new divide values glitch-free and reports lock/fault.
//
// state     | meaning
// ----------+------------------------------------------------------------
// OFF       | divider held in reset, config loads div_out directly
// SETTLE    | divider running, counting clk_div_in rises toward lock
// LOCKED    | divided clock usable, new config accepted as pending reload
// DRAIN_CFG | waiting for a low phase before reloading the pending value
// DRAIN_OFF | waiting for a low phase before shutting down
// HOLD      | divider held in reset while the new value is applied
module axi_clock_div_ctrl #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int DEFAULT_DIV    = 8,
    parameter int MIN_DIV        = 4,
    parameter int SETTLE_PERIODS = 2,
    parameter int HOLD_CYCLES    = 2,
    parameter int WDOG_CYCLES    = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic [AXI_DATA_WIDTH-1:0] cfg_div,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      clk_div_in,
    output logic [AXI_DATA_WIDTH-1:0] div_out,
    output logic                      div_rstn,
    output logic                      clk_en,
    output logic                      locked,
    output logic                      err_range,
    output logic                      fault
);

    localparam int EW = $clog2(SETTLE_PERIODS + 1);
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [EW-1:0]             EDGE_LAST = EW'(SETTLE_PERIODS - 1);
    localparam logic [WW-1:0]             WDOG_MAX  = WW'(WDOG_CYCLES);
    localparam logic [HW-1:0]             HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [AXI_DATA_WIDTH-1:0] DIV_DEF   = AXI_DATA_WIDTH'(DEFAULT_DIV);
    localparam logic [AXI_DATA_WIDTH-1:0] DIV_MIN   = AXI_DATA_WIDTH'(MIN_DIV);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_SETTLE    = 3'd1,
        S_LOCKED    = 3'd2,
        S_DRAIN_CFG = 3'd3,
        S_DRAIN_OFF = 3'd4,
        S_HOLD      = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_DATA_WIDTH-1:0] div_q, div_d;
    logic [AXI_DATA_WIDTH-1:0] pend_q, pend_d;
    logic                      pend_vld_q, pend_vld_d;
    logic                      div_rstn_q, div_rstn_d;
    logic                      clk_en_q, clk_en_d;
    logic                      locked_q, locked_d;
    logic                      err_q, err_d;
    logic                      fault_q, fault_d;
    logic                      ready_q, ready_d;
    logic [EW-1:0]             edge_q, edge_d;
    logic [WW-1:0]             wdog_q, wdog_d;
    logic [HW-1:0]             hold_q, hold_d;
    logic                      samp_q, prev_q;

    logic          rise, fall, cfg_legal, xfer, go_off, wdog_trip;
    logic [WW-1:0] wdog_inc;

    assign rise      = samp_q & ~prev_q;
    assign fall      = ~samp_q & prev_q;
    assign cfg_legal = (cfg_div == '0) || ((cfg_div >= DIV_MIN) && !cfg_div[0]);
    assign xfer      = cfg_valid & ready_q;
    assign wdog_inc  = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WW'(1);
    assign wdog_trip = (wdog_inc == WDOG_MAX);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_OFF;
            div_q      <= DIV_DEF;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            div_rstn_q <= 1'b0;
            clk_en_q   <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            fault_q    <= 1'b0;
            ready_q    <= 1'b0;
            edge_q     <= '0;
            wdog_q     <= '0;
            hold_q     <= '0;
            samp_q     <= 1'b0;
            prev_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            div_rstn_q <= div_rstn_d;
            clk_en_q   <= clk_en_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            fault_q    <= fault_d;
            ready_q    <= ready_d;
            edge_q     <= edge_d;
            wdog_q     <= wdog_d;
            hold_q     <= hold_d;
            samp_q     <= clk_div_in;
            prev_q     <= samp_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        div_rstn_d = div_rstn_q;
        clk_en_d   = clk_en_q;
        locked_d   = locked_q;
        err_d      = xfer & ~cfg_legal;
        fault_d    = fault_q;
        edge_d     = edge_q;
        wdog_d     = wdog_q;
        hold_d     = hold_q;
        go_off     = 1'b0;

        case (state_q)
            S_OFF: begin
                div_rstn_d = 1'b0;
                clk_en_d   = 1'b0;
                locked_d   = 1'b0;
                if (xfer && cfg_legal) div_d = cfg_div;
                if (!enable) begin
                    fault_d = 1'b0;
                end else if (!fault_q) begin
                    state_d    = S_SETTLE;
                    div_rstn_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!enable) begin
                    go_off = 1'b1;
                end else if (rise) begin
                    wdog_d = '0;
                    if (edge_q == EDGE_LAST) begin
                        state_d  = S_LOCKED;
                        locked_d = 1'b1;
                        clk_en_d = 1'b1;
                    end else begin
                        edge_d = edge_q + EW'(1);
                    end
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_trip) begin
                        fault_d = 1'b1;
                        go_off  = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                // A transfer racing enable falling is still latched; it lands on OFF entry.
                if (xfer && cfg_legal) begin
                    pend_d     = cfg_div;
                    pend_vld_d = 1'b1;
                end
                if (!enable) state_d = S_DRAIN_OFF;
                else if (xfer && cfg_legal) state_d = S_DRAIN_CFG;
            end
            S_DRAIN_CFG, S_DRAIN_OFF: begin
                if (state_q == S_DRAIN_CFG && !enable) begin
                    go_off = 1'b1;
                end else if (fall) begin
                    if (state_q == S_DRAIN_OFF) begin
                        go_off = 1'b1;
                    end else begin
                        state_d    = S_HOLD;
                        clk_en_d   = 1'b0;
                        locked_d   = 1'b0;
                        div_rstn_d = 1'b0;
                        div_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_trip) begin
                        fault_d = 1'b1;
                        go_off  = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!enable) begin
                    go_off = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d    = S_SETTLE;
                    div_rstn_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: go_off = 1'b1;
        endcase

        if (go_off) begin
            state_d    = S_OFF;
            div_rstn_d = 1'b0;
            clk_en_d   = 1'b0;
            locked_d   = 1'b0;
            if (pend_vld_q) begin
                div_d      = pend_q;
                pend_vld_d = 1'b0;
            end
        end

        if (state_d != state_q) begin
            edge_d = '0;
            wdog_d = '0;
            hold_d = '0;
        end

        ready_d = (state_d == S_OFF) || (state_d == S_LOCKED);
    end

    assign cfg_ready = ready_q;
    assign div_out   = div_q;
    assign div_rstn  = div_rstn_q;
    assign clk_en    = clk_en_q;
    assign locked    = locked_q;
    assign err_range = err_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_axi_clock_div_ctrl.sv
// Bench for axi_clock_div_ctrl: behavioural divider model in the loop, config
// transfers scored through a queue, plus timed reload/abort/watchdog sequences.
module tb_axi_clock_div_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [31:0] cfg_div;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        clk_div_in;
    logic [31:0] div_out;
    logic        div_rstn;
    logic        clk_en;
    logic        locked;
    logic        err_range;
    logic        fault;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic force_low = 1'b0;
    int dcnt = 0;

    axi_clock_div_ctrl #(
        .AXI_DATA_WIDTH(32),
        .DEFAULT_DIV   (8),
        .MIN_DIV       (4),
        .SETTLE_PERIODS(2),
        .HOLD_CYCLES   (2),
        .WDOG_CYCLES   (64)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .clk_div_in(clk_div_in),
        .div_out   (div_out),
        .div_rstn  (div_rstn),
        .clk_en    (clk_en),
        .locked    (locked),
        .err_range (err_range),
        .fault     (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: clockDiv = 0 means its built-in default period of 6.
    function automatic int period(input logic [31:0] d);
        return (d == 0) ? 6 : int'(d);
    endfunction

    always @(posedge clk) begin
        if (!div_rstn || force_low) begin
            dcnt       <= 0;
            clk_div_in <= 1'b0;
        end else begin
            dcnt       <= (dcnt == period(div_out) - 1) ? 0 : dcnt + 1;
            clk_div_in <= (dcnt >= period(div_out) / 2);
        end
    end

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] dv;
    } sb_t;
    sb_t sb[$];
    sb_t ent;

    typedef struct {
        logic [31:0] div;
        logic        err;
        logic [31:0] exp_div;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            ent = sb.pop_front();
            chk("sb_err_range", {31'd0, err_range}, {31'd0, ent.err});
            chk("sb_div_out", div_out, ent.dv);
        end
        if (clk_en) begin
            total++;
            if (!div_rstn || !locked) begin
                bad++;
                $display("FAIL clk_en_safety: clk_en=1 with div_rstn=%0d locked=%0d", div_rstn, locked);
            end
        end
    end

    function automatic logic cond(input int which);
        case (which)
            0:       return locked;
            1:       return !div_rstn;
            2:       return div_rstn;
            default: return fault;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, output int n);
        n = 0;
        while (!cond(which) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!cond(which)) begin
            total++;
            bad++;
            $display("FAIL wait_timeout: condition %0d not seen after %0d cycles", which, n);
        end
    endtask

    task automatic xfer(input logic [31:0] v, input logic e_err, input logic [31:0] e_div);
        int tries = 0;
        cfg_div   = v;
        cfg_valid = 1'b1;
        while (!cfg_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!cfg_ready) begin
            total++;
            bad++;
            $display("FAIL xfer_ready: cfg_ready %0d for value %0d", cfg_ready, v);
            cfg_valid = 1'b0;
        end else begin
            sb.push_back('{cyc + 1, e_err, e_div});
            @(negedge clk);
            cfg_valid = 1'b0;
        end
    endtask

    task automatic relock(input int lo, input int hi, input string nm);
        int n;
        wait_for(2, 40, n);
        wait_for(0, 200, n);
        chk_rng(nm, n, lo, hi);
        chk("relock_clk_en", {31'd0, clk_en}, 32'd1);
        chk("relock_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{32'd12, 1'b0, 32'd12};
        vecs[1] = '{32'd3,  1'b1, 32'd12};
        vecs[2] = '{32'd7,  1'b1, 32'd12};
        vecs[3] = '{32'd2,  1'b1, 32'd12};
        vecs[4] = '{32'd4,  1'b0, 32'd4};
        vecs[5] = '{32'd5,  1'b1, 32'd4};
        vecs[6] = '{32'd0,  1'b0, 32'd0};
        vecs[7] = '{32'd13, 1'b1, 32'd0};
        vecs[8] = '{32'd8,  1'b0, 32'd8};

        rstn = 1'b0; enable = 1'b0; cfg_div = '0; cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_div_out", div_out, 32'd8);
        chk("rst_div_rstn", {31'd0, div_rstn}, 32'd0);
        chk("rst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err", {31'd0, err_range}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        rstn = 1'b1;

        // Config loads while OFF.
        for (int i = 0; i < 9; i++) xfer(vecs[i].div, vecs[i].err, vecs[i].exp_div);
        chk("off_div_rstn", {31'd0, div_rstn}, 32'd0);

        // First lock at the default period of 8.
        enable = 1'b1;
        @(negedge clk);
        chk("en_div_rstn", {31'd0, div_rstn}, 32'd1);
        wait_for(0, 200, n);
        chk_rng("lock8_cycles", n, 14, 16);
        chk("lock8_clk_en", {31'd0, clk_en}, 32'd1);
        chk("lock8_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        // Reload to 20.
        xfer(32'd20, 1'b0, 32'd8);
        chk("reload_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        wait_for(1, 60, n);
        chk("hold_clk_en", {31'd0, clk_en}, 32'd0);
        chk("hold_div_out", div_out, 32'd20);
        wait_for(2, 20, n);
        chk("hold_cycles", n, 32'd2);
        wait_for(0, 200, n);
        chk_rng("lock20_cycles", n, 32, 34);
        chk("lock20_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        // Illegal values rejected, then 0 accepted.
        xfer(32'd3, 1'b1, 32'd20);
        xfer(32'd7, 1'b1, 32'd20);
        xfer(32'd0, 1'b0, 32'd20);
        wait_for(1, 60, n);
        chk("reload0_div_out", div_out, 32'd0);
        wait_for(2, 20, n);
        chk("hold0_cycles", n, 32'd2);
        wait_for(0, 200, n);
        chk_rng("lock6_cycles", n, 11, 13);

        // enable dropped in LOCKED: OFF after the next fall.
        enable = 1'b0;
        wait_for(1, 30, n);
        chk_rng("drain_off_cycles", n, 1, 10);
        chk("drain_off_clk_en", {31'd0, clk_en}, 32'd0);
        chk("drain_off_locked", {31'd0, locked}, 32'd0);
        chk("drain_off_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        // enable falling together with a transfer: value lands on OFF entry.
        enable = 1'b1;
        relock(11, 13, "lock6b_cycles");
        enable = 1'b0;
        xfer(32'd12, 1'b0, 32'd0);
        wait_for(1, 30, n);
        chk("race_div_out", div_out, 32'd12);

        // enable dropped in HOLD: OFF the next cycle.
        enable = 1'b1;
        relock(20, 22, "lock12_cycles");
        xfer(32'd8, 1'b0, 32'd12);
        wait_for(1, 60, n);
        chk("hold_abort_div_out", div_out, 32'd8);
        enable = 1'b0;
        @(negedge clk);
        chk("hold_abort_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("hold_abort_clk_en", {31'd0, clk_en}, 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_abort_div_rstn", {31'd0, div_rstn}, 32'd0);

        // Watchdog: divider output stuck low during SETTLE.
        force_low = 1'b1;
        enable    = 1'b1;
        @(negedge clk);
        chk("wdog_div_rstn_on", {31'd0, div_rstn}, 32'd1);
        wait_for(3, 200, n);
        chk_rng("wdog_cycles", n, 63, 65);
        chk("wdog_div_rstn", {31'd0, div_rstn}, 32'd0);
        chk("wdog_clk_en", {31'd0, clk_en}, 32'd0);
        force_low = 1'b0;
        repeat (10) @(negedge clk);
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        chk("fault_no_restart", {31'd0, div_rstn}, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        enable = 1'b1;
        relock(14, 16, "lock8b_cycles");

        // Synchronous reset in the middle of HOLD.
        xfer(32'd20, 1'b0, 32'd8);
        wait_for(1, 60, n);
        rstn = 1'b0;
        @(negedge clk);
        chk("hrst_div_out", div_out, 32'd8);
        chk("hrst_div_rstn", {31'd0, div_rstn}, 32'd0);
        chk("hrst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("hrst_locked", {31'd0, locked}, 32'd0);
        chk("hrst_fault", {31'd0, fault}, 32'd0);
        chk("hrst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        enable = 1'b0;
        rstn   = 1'b1;
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
